// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if: IFU, LSU and memory request/response channels of the memory arbiter
// Ports: slave = arbiter side, master = requester/memory side
interface mem_bus_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MASK_WIDTH = 8
);
  logic                  ifu_req_valid;
  logic                  ifu_req_ready;
  logic [ADDR_WIDTH-1:0] ifu_addr;
  logic                  ifu_rsp_valid;
  logic                  ifu_rsp_ready;
  logic [DATA_WIDTH-1:0] ifu_rdata;
  logic                  lsu_req_valid;
  logic                  lsu_req_ready;
  logic [ADDR_WIDTH-1:0] lsu_addr;
  logic                  lsu_wen;
  logic [DATA_WIDTH-1:0] lsu_wdata;
  logic [MASK_WIDTH-1:0] lsu_wmask;
  logic                  lsu_rsp_valid;
  logic                  lsu_rsp_ready;
  logic [DATA_WIDTH-1:0] lsu_rdata;
  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_wen;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [MASK_WIDTH-1:0] mem_wmask;
  logic                  mem_rsp_valid;
  logic                  mem_rsp_ready;
  logic [DATA_WIDTH-1:0] mem_rdata;
  modport slave (
    input  ifu_req_valid, ifu_addr, ifu_rsp_ready,
    input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask, lsu_rsp_ready,
    input  mem_req_ready, mem_rsp_valid, mem_rdata,
    output ifu_req_ready, ifu_rsp_valid, ifu_rdata,
    output lsu_req_ready, lsu_rsp_valid, lsu_rdata,
    output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask, mem_rsp_ready
  );
  modport master (
    output ifu_req_valid, ifu_addr, ifu_rsp_ready,
    output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask, lsu_rsp_ready,
    output mem_req_ready, mem_rsp_valid, mem_rdata,
    input  ifu_req_ready, ifu_rsp_valid, ifu_rdata,
    input  lsu_req_ready, lsu_rsp_valid, lsu_rdata,
    input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask, mem_rsp_ready
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory port between IFU (read) and LSU (read/write), one transaction in flight
// Ports: clk, rst (sync, active-high), bus = IFU/LSU/memory valid-ready channels (slave modport)
module mem_bus_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int MASK_WIDTH   = 8,
  parameter bit LSU_PRIORITY = 1'b1
) (
  input logic              clk,
  input logic              rst,
  mem_bus_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP, RESP} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_IFU, OWN_LSU} owner_t;
  state_t                r_state, w_next;
  owner_t                r_owner;
  logic                  r_last_lsu;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_wen;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [MASK_WIDTH-1:0] r_wmask;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  w_pick_lsu, w_grant_ifu, w_grant_lsu, w_rsp_hs;
  // a tie goes to LSU in fixed-priority mode, otherwise to whoever did not win last
  assign w_pick_lsu  = bus.lsu_req_valid && (!bus.ifu_req_valid || LSU_PRIORITY || !r_last_lsu);
  assign w_grant_lsu = (r_state == IDLE) && w_pick_lsu;
  assign w_grant_ifu = (r_state == IDLE) && bus.ifu_req_valid && !w_pick_lsu;
  assign w_rsp_hs    = (bus.ifu_rsp_valid && bus.ifu_rsp_ready) || (bus.lsu_rsp_valid && bus.lsu_rsp_ready);
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     w_next = (w_grant_ifu || w_grant_lsu) ? ISSUE : IDLE;
      ISSUE:    w_next = bus.mem_req_ready ? WAIT_RSP : ISSUE;
      WAIT_RSP: w_next = bus.mem_rsp_valid ? RESP : WAIT_RSP;
      RESP:     w_next = w_rsp_hs ? IDLE : RESP;
      default:  w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_owner    <= OWN_NONE;
      r_last_lsu <= 1'b1;
      r_addr     <= '0;
      r_wen      <= 1'b0;
      r_wdata    <= '0;
      r_wmask    <= '0;
      r_rdata    <= '0;
    end else begin
      r_state <= w_next;
      if (w_grant_ifu || w_grant_lsu) begin
        r_owner    <= w_grant_lsu ? OWN_LSU : OWN_IFU;
        r_last_lsu <= w_grant_lsu;
        r_addr     <= w_grant_lsu ? bus.lsu_addr : bus.ifu_addr;
        r_wen      <= w_grant_lsu && bus.lsu_wen;
        r_wdata    <= w_grant_lsu ? bus.lsu_wdata : '0;
        r_wmask    <= w_grant_lsu ? bus.lsu_wmask : '0;
      end
      if (r_state == WAIT_RSP && bus.mem_rsp_valid) r_rdata <= bus.mem_rdata;
      if (r_state == RESP && w_rsp_hs) r_owner <= OWN_NONE;
    end
  end
  assign bus.ifu_req_ready = w_grant_ifu;
  assign bus.lsu_req_ready = w_grant_lsu;
  assign bus.mem_req_valid = r_state == ISSUE;
  assign bus.mem_addr      = r_addr;
  assign bus.mem_wen       = r_wen;
  assign bus.mem_wdata     = r_wdata;
  assign bus.mem_wmask     = r_wmask;
  assign bus.mem_rsp_ready = r_state == WAIT_RSP;
  assign bus.ifu_rsp_valid = (r_state == RESP) && (r_owner == OWN_IFU);
  assign bus.lsu_rsp_valid = (r_state == RESP) && (r_owner == OWN_LSU);
  assign bus.ifu_rdata     = r_rdata;
  assign bus.lsu_rdata     = r_rdata;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: table-driven scoreboard bench for both arbitration modes
module tb_mem_bus_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_rr = 1'b1;
  int checks = 0;
  int errors = 0;
  mem_bus_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MASK_WIDTH(8)) bus ();
  mem_bus_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MASK_WIDTH(8)) rb ();
  mem_bus_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MASK_WIDTH(8), .LSU_PRIORITY(1'b1)) u_fp (
    .clk(clk), .rst(rst), .bus(bus)
  );
  mem_bus_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MASK_WIDTH(8), .LSU_PRIORITY(1'b0)) u_rr (
    .clk(clk), .rst(rst_rr), .bus(rb)
  );
  always #5 clk = ~clk;
  typedef struct { logic [31:0] addr; logic wen; logic [31:0] wdata; logic [7:0] wmask; } mreq_t;
  typedef struct { logic lsu; logic [31:0] rdata; logic chk_data; } rsp_t;
  typedef struct {
    logic ifu_v; logic lsu_v; logic exp_lsu;
    logic [31:0] ifu_addr; logic [31:0] lsu_addr; logic lsu_wen;
    logic [31:0] wdata; logic [7:0] wmask; logic [31:0] rdata;
    int req_stall; int rsp_stall;
  } vec_t;
  mreq_t exp_mem[$];
  rsp_t  exp_rsp[$];
  vec_t  vecs[7];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask
  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask
  task automatic pop_rsp(input logic lsu, input logic [31:0] data);
    rsp_t r;
    if (exp_rsp.size() == 0) begin
      fail("rsp_unexpected");
      return;
    end
    r = exp_rsp.pop_front();
    chk("rsp_owner", lsu, r.lsu);
    if (r.chk_data) chk("rsp_rdata", data, r.rdata);
  endtask
  always @(negedge clk) begin : mon
    mreq_t m;
    if (!rst) begin
      if (bus.mem_req_valid && bus.mem_req_ready) begin
        if (exp_mem.size() == 0) fail("mem_unexpected");
        else begin
          m = exp_mem.pop_front();
          chk("mem_addr", bus.mem_addr, m.addr);
          chk("mem_wen", bus.mem_wen, m.wen);
          chk("mem_wmask", bus.mem_wmask, m.wmask);
          if (m.wen) chk("mem_wdata", bus.mem_wdata, m.wdata);
        end
      end
      if (bus.ifu_rsp_valid && bus.lsu_rsp_valid) fail("rsp_both_valid");
      if (bus.ifu_rsp_valid && bus.ifu_rsp_ready) pop_rsp(1'b0, bus.ifu_rdata);
      if (bus.lsu_rsp_valid && bus.lsu_rsp_ready) pop_rsp(1'b1, bus.lsu_rdata);
    end
  end
  task automatic set_rsp_ready(input logic lsu, input logic val);
    if (lsu) bus.lsu_rsp_ready = val;
    else bus.ifu_rsp_ready = val;
  endtask
  task automatic apply(input vec_t v);
    int wait_n;
    logic found;
    mreq_t em;
    found = 1'b0;
    wait_n = 0;
    if (v.ifu_v) begin
      bus.ifu_req_valid = 1'b1;
      bus.ifu_addr = v.ifu_addr;
    end
    if (v.lsu_v) begin
      bus.lsu_req_valid = 1'b1;
      bus.lsu_addr = v.lsu_addr;
      bus.lsu_wen = v.lsu_wen;
      bus.lsu_wdata = v.wdata;
      bus.lsu_wmask = v.wmask;
    end
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.ifu_req_ready || bus.lsu_req_ready) begin
        found = 1'b1;
        wait_n = k;
        break;
      end
    end
    if (!found) begin
      fail("accept_timeout");
      return;
    end
    chk("accept_cycle", wait_n, 0);
    chk("grant_lsu", bus.lsu_req_ready, v.exp_lsu);
    chk("grant_onehot", bus.ifu_req_ready && bus.lsu_req_ready, 0);
    em = v.exp_lsu ? '{v.lsu_addr, v.lsu_wen, v.wdata, v.wmask} : '{v.ifu_addr, 1'b0, 32'h0, 8'h00};
    exp_mem.push_back(em);
    @(posedge clk);
    #1;
    if (v.exp_lsu) bus.lsu_req_valid = 1'b0;
    else bus.ifu_req_valid = 1'b0;
    bus.mem_req_ready = (v.req_stall == 0);
    for (int k = 0; k < v.req_stall; k++) begin
      @(negedge clk);
      chk("stall_valid", bus.mem_req_valid, 1);
      chk("stall_addr", bus.mem_addr, em.addr);
      chk("stall_wen", bus.mem_wen, em.wen);
      chk("stall_wmask", bus.mem_wmask, em.wmask);
      if (em.wen) chk("stall_wdata", bus.mem_wdata, em.wdata);
      chk("stall_ifu_ready", bus.ifu_req_ready, 0);
      @(posedge clk);
      #1;
    end
    bus.mem_req_ready = 1'b1;
    @(negedge clk);
    chk("issue_valid", bus.mem_req_valid, 1);
    chk("issue_rsp_ready", bus.mem_rsp_ready, 0);
    @(posedge clk);
    #1;
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rdata = v.rdata;
    exp_rsp.push_back('{v.exp_lsu, v.rdata, !(v.exp_lsu && v.lsu_wen)});
    @(negedge clk);
    chk("wait_rsp_ready", bus.mem_rsp_ready, 1);
    chk("wait_req_valid", bus.mem_req_valid, 0);
    chk("early_rsp", v.exp_lsu ? bus.lsu_rsp_valid : bus.ifu_rsp_valid, 0);
    @(posedge clk);
    #1;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rdata = $urandom;
    set_rsp_ready(v.exp_lsu, v.rsp_stall == 0);
    for (int k = 0; k < v.rsp_stall; k++) begin
      @(negedge clk);
      chk("held_valid", v.exp_lsu ? bus.lsu_rsp_valid : bus.ifu_rsp_valid, 1);
      chk("held_rdata", v.exp_lsu ? bus.lsu_rdata : bus.ifu_rdata, v.rdata);
      chk("held_ifu_req_ready", bus.ifu_req_ready, 0);
      chk("held_lsu_req_ready", bus.lsu_req_ready, 0);
      @(posedge clk);
      #1;
    end
    set_rsp_ready(v.exp_lsu, 1'b1);
    @(negedge clk);
    chk("rsp_valid", v.exp_lsu ? bus.lsu_rsp_valid : bus.ifu_rsp_valid, 1);
    chk("other_rsp_valid", v.exp_lsu ? bus.ifu_rsp_valid : bus.lsu_rsp_valid, 0);
    @(posedge clk);
    #1;
    set_rsp_ready(v.exp_lsu, 1'b0);
  endtask
  task automatic chk_all_zero(input string tag);
    chk({tag, "_mem_req_valid"}, bus.mem_req_valid, 0);
    chk({tag, "_mem_rsp_ready"}, bus.mem_rsp_ready, 0);
    chk({tag, "_ifu_req_ready"}, bus.ifu_req_ready, 0);
    chk({tag, "_lsu_req_ready"}, bus.lsu_req_ready, 0);
    chk({tag, "_ifu_rsp_valid"}, bus.ifu_rsp_valid, 0);
    chk({tag, "_lsu_rsp_valid"}, bus.lsu_rsp_valid, 0);
    chk({tag, "_mem_addr"}, bus.mem_addr, 0);
    chk({tag, "_mem_wen"}, bus.mem_wen, 0);
    chk({tag, "_mem_wdata"}, bus.mem_wdata, 0);
    chk({tag, "_mem_wmask"}, bus.mem_wmask, 0);
    chk({tag, "_rdata"}, bus.ifu_rdata, 0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog_timeout");
    $fatal(1);
  end
  initial begin
    int n;
    int grant_at[4];
    logic grant_lsu[4];
    // ifu_v lsu_v exp_lsu ifu_addr lsu_addr lsu_wen wdata wmask rdata req_stall rsp_stall
    vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h8000_0000, 32'h0, 1'b0, 32'h0, 8'h00, 32'h0000_0413, 0, 0};
    vecs[1] = '{1'b0, 1'b1, 1'b1, 32'h0, 32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 8'h0F, 32'h0, 3, 0};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 32'h8000_0004, 32'h8000_2000, 1'b0, 32'h0, 8'h00, 32'hCAFE_F00D, 0, 5};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 32'h8000_0004, 32'h0, 1'b0, 32'h0, 8'h00, 32'h0010_0093, 0, 0};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 32'h8000_0008, 32'h8000_3000, 1'b1, 32'h1234_5678, 8'hFF, 32'h0, 2, 1};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 32'h8000_0008, 32'h0, 1'b0, 32'h0, 8'h00, 32'h0020_8113, 1, 2};
    vecs[6] = '{1'b0, 1'b1, 1'b1, 32'h0, 32'h8000_4000, 1'b0, 32'h0, 8'h00, 32'hA5A5_0001, 0, 0};
    bus.ifu_req_valid = 0; bus.ifu_addr = 0; bus.ifu_rsp_ready = 0;
    bus.lsu_req_valid = 0; bus.lsu_addr = 0; bus.lsu_wen = 0; bus.lsu_wdata = 0; bus.lsu_wmask = 0;
    bus.lsu_rsp_ready = 0; bus.mem_req_ready = 0; bus.mem_rsp_valid = 0; bus.mem_rdata = 0;
    rb.ifu_req_valid = 0; rb.ifu_addr = 32'h8000_0000; rb.ifu_rsp_ready = 0;
    rb.lsu_req_valid = 0; rb.lsu_addr = 32'h8000_1000; rb.lsu_wen = 0; rb.lsu_wdata = 0; rb.lsu_wmask = 0;
    rb.lsu_rsp_ready = 0; rb.mem_req_ready = 0; rb.mem_rsp_valid = 0; rb.mem_rdata = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 7; i++) apply(vecs[i]);
    bus.ifu_req_valid = 1'b1;
    bus.ifu_addr = 32'h8000_0100;
    @(negedge clk);
    chk("rst_seq_ifu_ready", bus.ifu_req_ready, 1);
    exp_mem.push_back('{32'h8000_0100, 1'b0, 32'h0, 8'h00});
    @(posedge clk);
    #1;
    bus.ifu_req_valid = 1'b0;
    bus.mem_req_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.mem_req_ready = 1'b0;
    @(negedge clk);
    chk("rst_seq_in_wait", bus.mem_rsp_ready, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    chk_all_zero("after_rst");
    repeat (2) begin
      @(posedge clk);
      #1;
      bus.ifu_rsp_ready = 1'b1;
      @(negedge clk);
      chk("late_rsp_ignored", bus.mem_rsp_ready, 0);
      chk("late_no_ifu_rsp", bus.ifu_rsp_valid, 0);
    end
    @(posedge clk);
    #1;
    bus.mem_rsp_valid = 1'b0;
    bus.ifu_rsp_ready = 1'b0;
    apply(vecs[0]);
    rb.ifu_req_valid = 1'b1;
    rb.lsu_req_valid = 1'b1;
    rb.mem_req_ready = 1'b1;
    rb.mem_rsp_valid = 1'b1;
    rb.mem_rdata = 32'h0000_0055;
    rb.ifu_rsp_ready = 1'b1;
    rb.lsu_rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rst_rr = 1'b0;
    n = 0;
    for (int c = 0; c < 40 && n < 4; c++) begin
      @(negedge clk);
      if (rb.ifu_req_ready || rb.lsu_req_ready) begin
        grant_lsu[n] = rb.lsu_req_ready;
        grant_at[n] = c;
        n++;
      end
    end
    chk("rr_grant_count", n, 4);
    for (int i = 0; i < n; i++) begin
      chk("rr_grant_order", grant_lsu[i], (i % 2 == 1));
      if (i > 0) chk("rr_spacing", grant_at[i] - grant_at[i-1], 4);
    end
    chk("mem_queue_empty", exp_mem.size(), 0);
    chk("rsp_queue_empty", exp_rsp.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
